// File: rtl/mem_wb_if.sv
// rtl/mem_wb_if.sv - handshake and data bundle between the MEM and WB pipeline stages
interface mem_wb_if #(
    parameter int XLEN   = 32,
    parameter int VLANES = 3,
    parameter int LANE_W = 16,
    parameter int RAW    = 5,
    parameter int CNT_W  = 16
) ();
    localparam int VW = VLANES * LANE_W;

    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [XLEN-1:0]   in_alu_res;
    logic [VW-1:0]     in_mem_data;
    logic [VW-1:0]     in_vec_res;
    logic [XLEN-1:0]   in_imm;
    logic [RAW-1:0]    in_rd;
    logic [RAW-1:0]    in_vd;
    logic              in_reg_write;
    logic              in_vreg_write;
    logic [1:0]        in_mem2reg;
    logic [VLANES-1:0] in_lane_mask;
    logic              out_valid;
    logic              out_ready;
    logic [RAW-1:0]    out_rd;
    logic [RAW-1:0]    out_vd;
    logic              out_reg_we;
    logic [VLANES-1:0] out_lane_we;
    logic [XLEN-1:0]   out_wb_scalar;
    logic [VW-1:0]     out_wb_vec;
    logic [CNT_W-1:0]  stall_cnt;

    modport slave (
        input  in_valid, flush, in_alu_res, in_mem_data, in_vec_res, in_imm,
               in_rd, in_vd, in_reg_write, in_vreg_write, in_mem2reg, in_lane_mask,
               out_ready,
        output in_ready, out_valid, out_rd, out_vd, out_reg_we, out_lane_we,
               out_wb_scalar, out_wb_vec, stall_cnt
    );

    modport master (
        output in_valid, flush, in_alu_res, in_mem_data, in_vec_res, in_imm,
               in_rd, in_vd, in_reg_write, in_vreg_write, in_mem2reg, in_lane_mask,
               out_ready,
        input  in_ready, out_valid, out_rd, out_vd, out_reg_we, out_lane_we,
               out_wb_scalar, out_wb_vec, stall_cnt
    );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with skid buffer, writeback select and stall counter
module mem_wb_stage #(
    parameter int XLEN   = 32,
    parameter int VLANES = 3,
    parameter int LANE_W = 16,
    parameter int RAW    = 5,
    parameter int CNT_W  = 16
) (
    input  logic     clk,
    input  logic     rst,
    mem_wb_if.slave  bus
);
    localparam int VW = VLANES * LANE_W;

    typedef struct packed {
        logic [XLEN-1:0]   alu_res;
        logic [VW-1:0]     mem_data;
        logic [VW-1:0]     vec_res;
        logic [XLEN-1:0]   imm;
        logic [RAW-1:0]    rd;
        logic [RAW-1:0]    vd;
        logic              reg_write;
        logic              vreg_write;
        logic [1:0]        mem2reg;
        logic [VLANES-1:0] lane_mask;
    } entry_t;

    entry_t           in_e, main_e, skid_e;
    logic             main_v, skid_v, rdy_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_fire, out_fire, advance;

    always_comb begin
        in_e = '{alu_res: bus.in_alu_res, mem_data: bus.in_mem_data, vec_res: bus.in_vec_res,
                 imm: bus.in_imm, rd: bus.in_rd, vd: bus.in_vd, reg_write: bus.in_reg_write,
                 vreg_write: bus.in_vreg_write, mem2reg: bus.in_mem2reg,
                 lane_mask: bus.in_lane_mask};
    end

    assign in_fire  = bus.in_valid & rdy_q;
    assign out_fire = main_v & bus.out_ready;
    // main can take a new entry when it is empty or being drained this cycle
    assign advance  = out_fire | ~main_v;

    // rdy_q always mirrors !skid_v, so skid and input never compete for main
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_e <= '0;
            skid_e <= '0;
            rdy_q  <= 1'b1;
        end else if (bus.flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b1;
        end else if (advance) begin
            if (skid_v) begin
                main_e <= skid_e;
                main_v <= 1'b1;
                skid_v <= 1'b0;
                rdy_q  <= 1'b1;
            end else begin
                main_v <= in_fire;
                if (in_fire) main_e <= in_e;
            end
        end else if (in_fire) begin
            skid_e <= in_e;
            skid_v <= 1'b1;
            rdy_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (main_v && !bus.out_ready && !bus.flush && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        bus.out_wb_scalar = '0;
        case (main_e.mem2reg)
            2'b00:   bus.out_wb_scalar = main_e.alu_res;
            2'b01:   bus.out_wb_scalar = main_e.mem_data[XLEN-1:0];
            2'b10:   bus.out_wb_scalar = main_e.imm;
            default: bus.out_wb_scalar = '0;
        endcase
    end

    assign bus.out_wb_vec  = (main_e.mem2reg == 2'b01) ? main_e.mem_data : main_e.vec_res;
    assign bus.in_ready    = rdy_q;
    assign bus.out_valid   = main_v;
    assign bus.out_rd      = main_e.rd;
    assign bus.out_vd      = main_e.vd;
    assign bus.out_reg_we  = main_v & main_e.reg_write & (main_e.rd != '0);
    assign bus.out_lane_we = {VLANES{main_v & main_e.vreg_write}} & main_e.lane_mask;
    assign bus.stall_cnt   = cnt_q;
endmodule
